// File: rtl/baseline_pkg.sv
// baseline_pkg: shared types and constants for the baseline sampling scheduler.
package baseline_pkg;
    localparam int          SAMPLE_W     = 14;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'd10;
    typedef enum logic [2:0] {IDLE, CLEAR, FILL, TRACK, VETO} state_t;
endpackage

// File: rtl/baseline_sample_sched_lfsr16.sv
// lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with load and advance.
module lfsr16
    import baseline_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [15:0] q
);
    // An all-zero state would lock up, so a zero seed loads 1 instead.
    always_ff @(posedge clk)
        if (load) q <= (seed == 16'd0) ? 16'd1 : seed;
        else if (adv) q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'd0);
endmodule

// File: rtl/baseline_sample_sched.sv
// baseline_sample_sched: pseudo-random sample strobes for the baseline estimator,
// with window-fill tracking and pulse veto.
module baseline_sample_sched
    import baseline_pkg::*;
#(
    parameter logic [15:0] SEED       = DEFAULT_SEED,
    parameter int          IW         = 8,
    parameter int          DEPTH_LOG2 = 8,
    parameter int          HOLDOFF    = 64
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] inp,
    input  logic signed [SAMPLE_W-1:0] baseline,
    input  logic [SAMPLE_W-1:0]        thr,
    output logic                       samp_en,
    output logic                       clr,
    output logic                       valid,
    output logic                       veto,
    output logic [15:0]                lfsr,
    output logic [DEPTH_LOG2:0]        fill_cnt,
    output logic [15:0]                drop_cnt
);
    localparam logic [DEPTH_LOG2:0] FULL      = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [7:0]          HOLD_INIT = 8'(HOLDOFF);

    state_t            state, state_next;
    logic [IW-1:0]     cnt;
    logic [7:0]        hold;
    logic [SAMPLE_W:0] diff, mag;
    logic              run, due, exc;

    // One extra bit keeps the difference of two extreme samples from wrapping.
    assign diff = {inp[SAMPLE_W-1], inp} - {baseline[SAMPLE_W-1], baseline};
    assign mag  = diff[SAMPLE_W] ? -diff : diff;
    assign exc  = mag > {1'b0, thr};
    assign run  = state == FILL || state == TRACK || state == VETO;
    assign due  = run && cnt == lfsr[IW-1:0];

    lfsr16 u_lfsr (
        .clk  (clk),
        .load (rst || state == CLEAR),
        .seed (SEED),
        .adv  (due),
        .q    (lfsr)
    );

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = CLEAR;
            CLEAR:   state_next = FILL;
            FILL:    if (due && fill_cnt == FULL - 1'b1) state_next = TRACK;
            TRACK:   if (exc) state_next = VETO;
            VETO:    if (!exc && hold == 8'd0) state_next = TRACK;
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

    always_comb begin
        samp_en = due && state != VETO;
        clr     = state == CLEAR;
        valid   = state == TRACK || state == VETO;
        veto    = state == VETO;
    end

    // The interval counter and LFSR keep running through a veto so the
    // strobe sequence is identical whether or not strobes are dropped.
    always_ff @(posedge clk)
        if (rst || state == CLEAR) begin
            cnt      <= '0;
            fill_cnt <= '0;
            drop_cnt <= '0;
            hold     <= '0;
        end else begin
            if (run) cnt <= due ? '0 : cnt + 1'b1;
            if (samp_en && fill_cnt != FULL) fill_cnt <= fill_cnt + 1'b1;
            if (due && veto && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            if (state == TRACK || (veto && exc)) hold <= HOLD_INIT;
            else if (veto && hold != 8'd0) hold <= hold - 1'b1;
        end
endmodule

// File: tb/tb_baseline_sample_sched.sv
// tb_baseline_sample_sched: directed + randomized checks against a countdown-based reference model.
module tb_baseline_sample_sched;
    localparam int S_IDLE = 0, S_CLEAR = 1, S_FILL = 2, S_TRACK = 3, S_VETO = 4;
    localparam logic [15:0] SEED = 16'd10;

    logic clk = 1'b0;
    logic rst, enable;
    logic signed [13:0] inp, baseline;
    logic [13:0] thr;
    logic samp_en, clr, valid, veto, z_samp_en, z_clr, z_valid, z_veto;
    logic [15:0] lfsr, drop_cnt, z_lfsr, z_drop_cnt;
    logic [8:0] fill_cnt, z_fill_cnt;

    int checks = 0, passes = 0, cyc = 0;
    int m_st, m_wait, m_fill, m_drop, m_hold;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    baseline_sample_sched dut (
        .clk(clk), .rst(rst), .enable(enable), .inp(inp), .baseline(baseline), .thr(thr),
        .samp_en(samp_en), .clr(clr), .valid(valid), .veto(veto),
        .lfsr(lfsr), .fill_cnt(fill_cnt), .drop_cnt(drop_cnt)
    );

    baseline_sample_sched #(.SEED(16'd0)) dut_z (
        .clk(clk), .rst(rst), .enable(enable), .inp(inp), .baseline(baseline), .thr(thr),
        .samp_en(z_samp_en), .clr(z_clr), .valid(z_valid), .veto(z_veto),
        .lfsr(z_lfsr), .fill_cnt(z_fill_cnt), .drop_cnt(z_drop_cnt)
    );

    function automatic logic [15:0] lfsr_next(logic [15:0] r);
        return {r[0], r[15], r[0] ^ r[14], r[0] ^ r[13], r[12], r[0] ^ r[11], r[10:1]};
    endfunction

    function automatic bit exc_now();
        int a, b, d;
        a = inp;
        b = baseline;
        d = a - b;
        if (d < 0) d = -d;
        return d > int'(thr);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: strobe falls due when the countdown to the next interval reaches zero.
    task automatic model_step();
        bit due, run, ex;
        ex  = exc_now();
        run = m_st == S_FILL || m_st == S_TRACK || m_st == S_VETO;
        due = run && m_wait == 0;
        if (rst) begin
            m_st = S_IDLE; m_lfsr = SEED; m_fill = 0; m_drop = 0; m_wait = 0; m_hold = 0;
        end else begin
            case (m_st)
                S_IDLE:  if (enable) m_st = S_CLEAR;
                S_CLEAR: begin
                    m_lfsr = SEED; m_wait = int'(SEED[7:0]); m_fill = 0; m_drop = 0; m_st = S_FILL;
                end
                S_FILL:  if (due) begin
                    m_fill++;
                    if (m_fill == 256) m_st = S_TRACK;
                end
                S_TRACK: begin
                    if (due && m_fill < 256) m_fill++;
                    if (ex) begin m_st = S_VETO; m_hold = 64; end
                end
                S_VETO: begin
                    if (due && m_drop < 65535) m_drop++;
                    if (ex) m_hold = 64;
                    else if (m_hold == 0) m_st = S_TRACK;
                    else m_hold--;
                end
                default: m_st = S_IDLE;
            endcase
            if (run) begin
                if (due) begin
                    m_lfsr = lfsr_next(m_lfsr);
                    m_wait = int'(m_lfsr[7:0]);
                end else m_wait--;
            end
            if (!enable) m_st = S_IDLE;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk("samp_en", samp_en, ((m_st == S_FILL || m_st == S_TRACK) && m_wait == 0) ? 1 : 0);
        chk("clr", clr, m_st == S_CLEAR ? 1 : 0);
        chk("valid", valid, (m_st == S_TRACK || m_st == S_VETO) ? 1 : 0);
        chk("veto", veto, m_st == S_VETO ? 1 : 0);
        chk("lfsr", lfsr, m_lfsr);
        chk("fill_cnt", fill_cnt, m_fill);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic rand_inputs();
        inp = 14'($urandom);
        baseline = 14'($urandom);
    endtask

    initial begin
        int t, first, zfirst, last, nveto;
        rst = 1'b1; enable = 1'b0; inp = '0; baseline = '0; thr = 14'h3FFF;
        tick();
        tick();
        chk("z_reset_lfsr", z_lfsr, 1);
        chk("z_reset_strobes", {z_samp_en, z_clr, z_valid, z_veto}, 0);
        chk("z_reset_counts", {z_fill_cnt, z_drop_cnt}, 0);
        rst = 1'b0;
        tick();

        t = cyc; enable = 1'b1;
        tick();
        chk("startup_clr", clr, 1);
        first = -1; zfirst = -1;
        for (int i = 0; i < 30 && first < 0; i++) begin
            tick();
            if (z_samp_en && zfirst < 0) zfirst = cyc;
            if (samp_en) first = cyc;
        end
        chk("first_strobe_delay", first - t, 12);
        chk("seed0_strobe_delay", zfirst - t, 3);
        last = -1;
        for (int i = 0; i < 30 && last < 0; i++) begin
            tick();
            if (samp_en) last = cyc;
        end
        chk("second_strobe_gap", last - first, 6);

        for (int i = 0; i < 40000 && fill_cnt != 9'd100; i++) begin rand_inputs(); tick(); end
        chk("fill_100", fill_cnt, 100);
        enable = 1'b0;
        tick();
        chk("drop_valid", valid, 0);
        chk("drop_clr", clr, 0);
        tick(); tick();
        enable = 1'b1;
        tick();
        chk("reen_clr", clr, 1);
        tick();
        chk("reen_fill", fill_cnt, 0);
        chk("reen_lfsr", lfsr, SEED);

        last = -1;
        for (int i = 0; i < 70000 && !valid; i++) begin
            rand_inputs();
            tick();
            if (samp_en) last = cyc;
        end
        chk("valid_after_last_strobe", cyc - last, 1);
        chk("fill_full", fill_cnt, 256);
        chk("fill_no_veto", veto, 0);

        baseline = 14'sd0; thr = 14'd100; inp = 14'sd0;
        tick(); tick();
        nveto = 0;
        inp = 14'sd500;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) chk("veto_entry", veto, 1);
            if (veto) nveto++;
        end
        inp = 14'sd0;
        for (int i = 0; i < 200 && veto; i++) begin
            tick();
            if (veto) nveto++;
        end
        chk("veto_length", nveto, 84);

        inp = -14'sd101;
        tick();
        chk("neg_101_veto", veto, 1);
        inp = 14'sd0;
        for (int i = 0; i < 200 && veto; i++) tick();
        inp = -14'sd100;
        tick();
        chk("neg_100_no_veto", veto, 0);
        inp = -14'sd8192; baseline = 14'sd8191;
        tick();
        chk("extreme_veto", veto, 1);

        for (int i = 0; i < 2000; i++) begin
            baseline = 14'($urandom);
            inp = baseline + 14'($urandom_range(0, 400)) - 14'sd200;
            thr = 14'($urandom_range(0, 250));
            tick();
        end

        inp = -14'sd8192; baseline = 14'sd8191; thr = 14'd100;
        tick(); tick();
        chk("pre_rst_veto", veto, 1);
        rst = 1'b1;
        tick();
        chk("rst_strobes", {samp_en, clr, valid, veto}, 0);
        chk("rst_lfsr", lfsr, SEED);
        chk("rst_counts", {fill_cnt, drop_cnt}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
